// File: rtl/vector_group_writer.sv
// Write-side vector buffer filler: accepts a valid/ready element stream, writes it to RAM
// at sequential addresses and reports group/buffer completion. Optional macro: VGW_CIRCULAR_EN.
module vector_group_writer #(
    parameter int DIM    = 4,
    parameter int MAX    = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              release_pulse,  // "release" is a reserved word in SystemVerilog
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              group_done,
    output logic [ADDR_W-1:0] group_count,
    output logic              buffer_full
);

    localparam int ELEM_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(DIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX - 1);

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ELEM_W-1:0] elem_reg, elem_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              group_done_reg, group_done_next;
    logic [ADDR_W-1:0] group_count_reg, group_count_next;
    logic              buffer_full_reg, buffer_full_next;
    logic              beat;

`ifndef VGW_CIRCULAR_EN
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state_reg, state_next;

    assign ready_out = (state_reg == FILL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end
`else
    logic unused_release;

    // Circular mode never stalls; the reader handshake is not needed.
    assign ready_out      = 1'b1;
    assign unused_release = release_pulse;
`endif

    assign beat = valid_in & ready_out;

    always_comb begin
        addr_next        = addr_reg;
        elem_next        = elem_reg;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;
        group_done_next  = 1'b0;
        group_count_next = group_count_reg;
`ifndef VGW_CIRCULAR_EN
        state_next       = state_reg;
        buffer_full_next = buffer_full_reg;
`else
        buffer_full_next = 1'b0;
`endif

        if (beat) begin
            wr_en_next   = 1'b1;
            wr_addr_next = addr_reg;
            wr_data_next = data_in;

            if (elem_reg == ELEM_LAST) begin
                elem_next        = '0;
                group_done_next  = 1'b1;
                group_count_next = group_count_reg + ADDR_W'(1);
            end else begin
                elem_next = elem_reg + ELEM_W'(1);
            end

            if (addr_reg == ADDR_LAST) begin
                addr_next        = '0;
                buffer_full_next = 1'b1;
`ifndef VGW_CIRCULAR_EN
                state_next       = FULL;
`else
                // A new fill starts immediately, so completed groups restart from zero.
                group_count_next = '0;
`endif
            end else begin
                addr_next = addr_reg + ADDR_W'(1);
            end
        end
`ifndef VGW_CIRCULAR_EN
        else if (state_reg == FULL && release_pulse) begin
            state_next       = FILL;
            buffer_full_next = 1'b0;
            group_count_next = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_reg        <= '0;
            elem_reg        <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            group_done_reg  <= 1'b0;
            group_count_reg <= '0;
            buffer_full_reg <= 1'b0;
        end else begin
            addr_reg        <= addr_next;
            elem_reg        <= elem_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            group_done_reg  <= group_done_next;
            group_count_reg <= group_count_next;
            buffer_full_reg <= buffer_full_next;
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign group_done  = group_done_reg;
    assign group_count = group_count_reg;
    assign buffer_full = buffer_full_reg;

endmodule

// File: tb/tb_vector_group_writer.sv
// Self-checking bench for vector_group_writer: directed and random steps against a
// fill-count reference model; honours VGW_CIRCULAR_EN when defined.
module tb_vector_group_writer;

    localparam int DIM = 4;
    localparam int MAX = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       release_pulse = 1'b0;
    logic       ready_out;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       group_done;
    logic [2:0] group_count;
    logic       buffer_full;

    vector_group_writer #(.DIM(DIM), .MAX(MAX), .DATA_W(8), .ADDR_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .release_pulse(release_pulse),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .group_done   (group_done),
        .group_count  (group_count),
        .buffer_full  (buffer_full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    // Reference model: number of elements written in the current fill plus a full flag.
    int         m_fill = 0;
    bit         m_full = 0;
    logic       m_wr_en = 0;
    logic       m_gd = 0;
    logic       m_bf = 0;
    logic [2:0] m_addr = '0;
    logic [7:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
`ifdef VGW_CIRCULAR_EN
        return 1'b1;
`else
        return !m_full;
`endif
    endfunction

    task automatic check_outputs();
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("group_done", group_done, m_gd);
        chk("group_count", group_count, 32'(m_fill / DIM));
        chk("buffer_full", buffer_full, m_bf);
    endtask

    // Called just after a rising edge: drive inputs, check ready, clock once, check outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bit beat;
        valid_in      = v;
        data_in       = d;
        release_pulse = r;
        #1;
        chk("ready_out", ready_out, model_ready());
        beat = v && model_ready();
        @(posedge clock);
        m_wr_en = beat;
        m_gd    = 1'b0;
`ifdef VGW_CIRCULAR_EN
        m_bf = 1'b0;
`endif
        if (beat) begin
            m_addr = 3'(m_fill);
            m_data = d;
            m_fill++;
            m_gd = (m_fill % DIM == 0);
            if (m_fill == MAX) begin
`ifdef VGW_CIRCULAR_EN
                m_bf   = 1'b1;
                m_fill = 0;
`else
                m_full = 1'b1;
                m_bf   = 1'b1;
`endif
            end
        end
`ifndef VGW_CIRCULAR_EN
        else if (m_full && r) begin
            m_full = 1'b0;
            m_bf   = 1'b0;
            m_fill = 0;
        end
`endif
        #1;
        check_outputs();
        $display("step v=%0b d=%02h rel=%0b -> wr_en=%0b addr=%0d data=%02h gd=%0b gc=%0d bf=%0b rdy=%0b",
                 v, d, r, wr_en, wr_addr, wr_data, group_done, group_count, buffer_full, ready_out);
    endtask

    // Called just after a rising edge: async reset mid-cycle, held across one edge.
    task automatic do_reset();
        valid_in      = 1'b0;
        release_pulse = 1'b0;
        reset         = 1'b0;
        #1;
        m_fill = 0; m_full = 0; m_wr_en = 0; m_gd = 0; m_bf = 0; m_addr = '0; m_data = '0;
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("ready_after_reset", ready_out, 1'b1);
        @(posedge clock);
        #1;
        $display("reset applied and released");
    endtask

    initial begin
        logic [7:0] pat;
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b1;
        #1;
        chk("ready_after_reset", ready_out, 1'b1);
        @(posedge clock);
        #1;

        // Back-to-back fill; release on the final beat must be ignored.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), (i == 7));
        // Hold valid while full (writes continue in circular mode).
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hA0, 1'b0);

        // Toggling valid pattern 1,0,0,1,0,1,1.
        pat = 8'b1101001;
        for (int i = 0; i < 7; i++) step(pat[i], 8'($urandom_range(255)), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Reset after six beats, then a full refill.
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Release during fill after two beats.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(255)), 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic with occasional releases.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(1)), 8'($urandom_range(255)), ($urandom_range(3) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
